cgra_kernel_dispatcher: RTL

Parametrised next-generation kernel dispatcher for the CGRA. It accepts kernel-ID requests from the host register interface into a request queue and fetches each kernel's column mask from kernel memory. It finds free columns, optionally rotating the mask around the array with round-robin fairness, and drives the per-column acceleration request/acknowledge handshake. It tracks column occupancy internally and publishes the per-column accelerator map.

---
 rtl/cgra_pkg.sv | 15 +
 rtl/cgra_kernel_dispatcher_if.sv | 29 ++
 rtl/cgra_req_fifo.sv | 41 ++++
 rtl/cgra_kernel_dispatcher.sv | 112 +++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// cgra_pkg: shared dispatcher state type, default sizes and the mask rotate helper
package cgra_pkg;
  localparam int N_COL_DEF = 4;
  localparam int KER_ID_W_DEF = 4;
  localparam int MAX_COL = 32;
  localparam int IW = $clog2(MAX_COL);
  typedef enum logic [1:0] {IDLE, READ, FIND, WAIT_ACK} disp_state_t;
  function automatic logic [MAX_COL-1:0] rotl(input logic [MAX_COL-1:0] v, input int n, input int w);
    logic [MAX_COL-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_COL; i++)
      if (i < w) r[IW'((i + n) % w)] = v[IW'(i)];
    return r;
  endfunction
endpackage

// File: rtl/cgra_kernel_dispatcher_if.sv
// cgra_kernel_dispatcher_if: host request, kernel-memory and column handshake bundle
interface cgra_kernel_dispatcher_if import cgra_pkg::*; #(
  parameter int N_COL = N_COL_DEF,
  parameter int KER_ID_W = KER_ID_W_DEF,
  parameter int QUEUE_DEPTH = 4
);
  logic req_valid_i;
  logic [KER_ID_W-1:0] req_ker_id_i;
  logic req_ready_o;
  logic [$clog2(QUEUE_DEPTH):0] queue_cnt_o;
  logic kmem_rd_o;
  logic [KER_ID_W-1:0] ker_id_o;
  logic [N_COL-1:0] ker_col_mask_i;
  logic [N_COL-1:0] acc_req_o;
  logic acc_ack_i;
  logic [N_COL-1:0] acc_end_i;
  logic [N_COL-1:0] col_busy_o;
  logic [N_COL-1:0] col_acc_map_o [N_COL];
  logic evt_o;
  logic err_o;
  modport master (
    output req_valid_i, req_ker_id_i, ker_col_mask_i, acc_ack_i, acc_end_i,
    input req_ready_o, queue_cnt_o, kmem_rd_o, ker_id_o, acc_req_o, col_busy_o, col_acc_map_o, evt_o, err_o
  );
  modport slave (
    input req_valid_i, req_ker_id_i, ker_col_mask_i, acc_ack_i, acc_end_i,
    output req_ready_o, queue_cnt_o, kmem_rd_o, ker_id_o, acc_req_o, col_busy_o, col_acc_map_o, evt_o, err_o
  );
endinterface

// File: rtl/cgra_req_fifo.sv
// cgra_req_fifo: synchronous FIFO with registered occupancy count, any word width
module cgra_req_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input logic clk_i,
  input logic rst_ni,
  input logic push,
  input logic [W-1:0] din,
  input logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [CW-1:0] cnt
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  // Storage, written only when there is room
  always_ff @(posedge clk_i)
    if (do_push) mem[wp] <= din;
  // Pointers and count; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/cgra_kernel_dispatcher.sv
// cgra_kernel_dispatcher: queues kernel IDs, fetches column masks and places kernels on free columns
// CGRA_DISPATCH_ROTATE_EN enables rotated placement with a round-robin start offset
module cgra_kernel_dispatcher import cgra_pkg::*; #(
  parameter int N_COL = N_COL_DEF,
  parameter int KER_ID_W = KER_ID_W_DEF,
  parameter int QUEUE_DEPTH = 4
) (
  input logic clk_i,
  input logic rst_ni,
  cgra_kernel_dispatcher_if.slave bus
);
  disp_state_t state;
  logic [N_COL-1:0] mask_q, col_busy, cand;
  logic [KER_ID_W-1:0] head;
  logic [$clog2(QUEUE_DEPTH):0] cnt;
  logic full, empty, push, pop, fit, ack_fire;
  assign push = bus.req_valid_i && bus.req_ready_o && bus.req_ker_id_i != '0;
  assign pop = state == IDLE && !empty;
  assign ack_fire = state == WAIT_ACK && bus.acc_ack_i;
  assign bus.req_ready_o = !full;
  assign bus.queue_cnt_o = cnt;
  assign bus.col_busy_o = col_busy;
  cgra_req_fifo #(.W(KER_ID_W), .DEPTH(QUEUE_DEPTH)) fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(push), .din(bus.req_ker_id_i), .pop(pop),
    .dout(head), .full(full), .empty(empty), .cnt(cnt)
  );
`ifdef CGRA_DISPATCH_ROTATE_EN
  localparam int OW = $clog2(N_COL);
  logic [OW-1:0] rr_ptr, win_off, off;
  logic [MAX_COL-1:0] rot;
  int k;
  // Try offsets from rr_ptr upward; iterating in reverse lets the earliest fitting offset win
  always_comb begin
    fit = 1'b0;
    cand = '0;
    off = '0;
    rot = '0;
    k = 0;
    for (int i = N_COL - 1; i >= 0; i--) begin
      k = (int'(rr_ptr) + i) % N_COL;
      rot = rotl(MAX_COL'(mask_q), k, N_COL);
      if ((rot & MAX_COL'(col_busy)) == '0) begin
        fit = 1'b1;
        cand = rot[N_COL-1:0];
        off = OW'(k);
      end
    end
  end
`else
  assign cand = mask_q;
  assign fit = (mask_q & col_busy) == '0;
`endif
  // Dispatch FSM: pop a request, read its mask, place it, hold the request until ack
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      mask_q <= '0;
      bus.kmem_rd_o <= 1'b0;
      bus.ker_id_o <= '0;
      bus.acc_req_o <= '0;
      bus.err_o <= 1'b0;
`ifdef CGRA_DISPATCH_ROTATE_EN
      rr_ptr <= '0;
      win_off <= '0;
`endif
    end else begin
      bus.kmem_rd_o <= 1'b0;
      bus.err_o <= 1'b0;
      case (state)
        IDLE: if (!empty) begin
          bus.ker_id_o <= head;
          bus.kmem_rd_o <= 1'b1;
          state <= READ;
        end
        READ: begin
          mask_q <= bus.ker_col_mask_i;
          bus.err_o <= bus.ker_col_mask_i == '0;
          state <= bus.ker_col_mask_i == '0 ? IDLE : FIND;
        end
        FIND: if (fit) begin
          bus.acc_req_o <= cand;
`ifdef CGRA_DISPATCH_ROTATE_EN
          win_off <= off;
`endif
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (bus.acc_ack_i) begin
          bus.acc_req_o <= '0;
`ifdef CGRA_DISPATCH_ROTATE_EN
          rr_ptr <= win_off == OW'(N_COL - 1) ? '0 : win_off + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Column occupancy and sharing map: ack sets, end clears, set wins on a collision
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_busy <= '0;
      bus.evt_o <= 1'b0;
      for (int c = 0; c < N_COL; c++) bus.col_acc_map_o[c] <= '0;
    end else begin
      bus.evt_o <= |bus.acc_end_i;
      col_busy <= (col_busy & ~bus.acc_end_i) | (ack_fire ? bus.acc_req_o : '0);
      for (int c = 0; c < N_COL; c++)
        bus.col_acc_map_o[c] <= ack_fire && bus.acc_req_o[c] ? bus.acc_req_o :
                                bus.acc_end_i[c] ? '0 : bus.col_acc_map_o[c];
    end
  end
endmodule
